// File: rtl/div_unit.sv
// Multi-cycle restoring divider: remainder to HI, quotient to LO, one quotient bit per clock.
// Optional build macro DIV_UNSIGNED_EN adds the divUnsigned input for DIVU operation.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divControl,
`ifdef DIV_UNSIGNED_EN
  input  logic             divUnsigned,
`endif
  input  logic [WIDTH-1:0] aInput,
  input  logic [WIDTH-1:0] bInput,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CNT_W-1:0] cnt;
  logic             qneg, rneg;

  logic             is_unsigned;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

`ifdef DIV_UNSIGNED_EN
  assign is_unsigned = divUnsigned;
`else
  assign is_unsigned = 1'b0;
`endif

  // Magnitudes: negating the most negative value wraps to itself, which is the right unsigned magnitude
  assign a_neg = aInput[WIDTH-1] & ~is_unsigned;
  assign b_neg = bInput[WIDTH-1] & ~is_unsigned;
  assign a_mag = cond_neg(aInput, a_neg);
  assign b_mag = cond_neg(bInput, b_neg);

  // Trial subtraction needs one extra bit: the shifted remainder can reach 2*divisor-1
  assign trial   = {rem, quo[WIDTH-1]};
  assign diff    = trial - {1'b0, dvs};
  assign ge      = ~diff[WIDTH];
  assign rem_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ge};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (divControl && (bInput != '0)) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      done    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (divControl) begin
            if (bInput == '0) begin
              divZero <= 1'b1;
              done    <= 1'b1;
            end else begin
              quo     <= a_mag;
              dvs     <= b_mag;
              rem     <= '0;
              cnt     <= '0;
              qneg    <= a_neg ^ b_neg;
              rneg    <= a_neg;
              divZero <= 1'b0;
            end
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          LO   <= cond_neg(quo, qneg);
          HI   <= cond_neg(rem, rneg);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, reset abort, random operands vs 64-bit arithmetic model.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        divControl;
  logic        div_unsigned;
  logic [31:0] aInput, bInput;
  logic [31:0] HI, LO;
  logic        busy, done, divZero;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .divControl (divControl),
`ifdef DIV_UNSIGNED_EN
    .divUnsigned(div_unsigned),
`endif
    .aInput     (aInput),
    .bInput     (bInput),
    .HI         (HI),
    .LO         (LO),
    .busy       (busy),
    .done       (done),
    .divZero    (divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed results from 64-bit arithmetic so the overflow case needs no special handling
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic u,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (u) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic u, input int pulse_at);
    logic [31:0] eq, er;
    int k;
    int busy_low;
    bit seen;
    aInput = a;
    bInput = b;
    div_unsigned = u;
    divControl = 1'b1;
    @(posedge clk); #1;
    divControl = 1'b0;
    aInput = $urandom;
    bInput = $urandom;
    div_unsigned = 1'($urandom);
    if (b == 32'd0) begin
      check({tag, "_zdone"}, 32'(done), 32'd1);
      check({tag, "_zflag"}, 32'(divZero), 32'd1);
      check({tag, "_zbusy"}, 32'(busy), 32'd0);
      check({tag, "_zhi"}, HI, m_hi);
      check({tag, "_zlo"}, LO, m_lo);
      @(posedge clk); #1;
      check({tag, "_zdone_fall"}, 32'(done), 32'd0);
      return;
    end
    model(a, b, u, eq, er);
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    busy_low = 0;
    seen = 0;
    k = 0;
    while (k < 40 && !seen) begin
      @(posedge clk); #1;
      k++;
      divControl = (k == pulse_at - 1);
      if (done) seen = 1;
      else if (!busy) busy_low++;
    end
    divControl = 1'b0;
    check({tag, "_latency"}, 32'(k), 32'd33);
    check({tag, "_busy_run"}, 32'(busy_low), 32'd0);
    check({tag, "_lo"}, LO, eq);
    check({tag, "_hi"}, HI, er);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_dz"}, 32'(divZero), 32'd0);
    m_hi = er;
    m_lo = eq;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic ru;
    reset = 1'b0;
    divControl = 1'b0;
    div_unsigned = 1'b0;
    aInput = '0;
    bInput = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(divZero), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_div("d100_7", 32'd100, 32'd7, 1'b0, 0);
    check("d100_7_lo_const", LO, 32'd14);
    check("d100_7_hi_const", HI, 32'd2);
    run_div("dz5_0", 32'd5, 32'd0, 1'b0, 0);
    check("dz_hi_kept", HI, 32'd2);
    check("dz_lo_kept", LO, 32'd14);
    run_div("dm7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    check("dm7_2_lo_const", LO, 32'hFFFF_FFFD);
    check("dm7_2_hi_const", HI, 32'hFFFF_FFFF);
    run_div("d7_m2", 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
    check("d7_m2_hi_const", HI, 32'd1);
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    check("ovf_lo_const", LO, 32'h8000_0000);
    check("ovf_hi_const", HI, 32'd0);
    run_div("minmin", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_div("small_big", 32'd3, 32'h8000_0000, 1'b0, 0);

    // Abort a division with reset at E10
    aInput = 32'd100;
    bInput = 32'd7;
    divControl = 1'b1;
    @(posedge clk); #1;
    divControl = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    m_hi = '0;
    m_lo = '0;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_abort_done", 32'(done), 32'd0);
      check("post_abort_busy", 32'(busy), 32'd0);
    end
    run_div("d9_3", 32'd9, 32'd3, 1'b0, 5);
    check("d9_3_lo_const", LO, 32'd3);
    check("d9_3_hi_const", HI, 32'd0);

`ifdef DIV_UNSIGNED_EN
    run_div("u_ff_2", 32'hFFFF_FFFF, 32'd2, 1'b1, 0);
    check("u_ff_2_lo_const", LO, 32'h7FFF_FFFF);
    check("u_ff_2_hi_const", HI, 32'd1);
    run_div("s_ff_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
    check("s_ff_2_lo_const", LO, 32'd0);
    check("s_ff_2_hi_const", HI, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          rb = 32'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        1: rb = $urandom;
        2: rb = 32'd0;
        default: begin
          rb = $urandom;
          ra = 32'($urandom_range(0, 1000));
        end
      endcase
`ifdef DIV_UNSIGNED_EN
      ru = 1'($urandom_range(0, 1));
`else
      ru = 1'b0;
`endif
      run_div("rand", ra, rb, ru, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
